// File: rtl/data_memory_arbiter.sv
// Two-port arbiter in front of data_memory: one transaction in flight, IDLE -> MEM -> RESP.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed priority to port 0.
module data_memory_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int ROM_DEPTH  = 256,
  parameter int RAM_DEPTH  = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  logic [1:0]                req_we,
  input  logic [2*ADDR_WIDTH-1:0]   req_addr,
  input  logic [2*DATA_WIDTH-1:0]   req_wdata,
  output logic [1:0]                rsp_valid,
  input  logic [1:0]                rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      rsp_err,
  output logic [ADDR_WIDTH-1:0]     mem_address,
  output logic [DATA_WIDTH-1:0]     mem_w_data,
  output logic                      mem_ctrl_w,
  output logic                      mem_ctrl_r,
  input  logic [DATA_WIDTH-1:0]     mem_r_data,
  output logic                      busy,
  output logic                      owner
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MEM  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [31:0] ROM_END = 32'(ROM_DEPTH);
  localparam logic [31:0] RAM_END = 32'(ROM_DEPTH + RAM_DEPTH);

  logic [1:0]            state;
  logic                  owner_q;
  logic                  we_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  win;
  logic                  accept;
  logic                  win_we;
  logic                  win_err;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;
  logic [31:0]           addr_ext;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic rr_ptr;

  // Pointer names the port that wins the next contended cycle.
  assign win = (req_valid == 2'b11) ? rr_ptr : (req_valid[1] & ~req_valid[0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (accept) begin
      rr_ptr <= ~win;
    end
  end
`else
  assign win = ~req_valid[0];
`endif

  assign accept    = (state == S_IDLE) && (|req_valid);
  assign win_addr  = win ? req_addr[ADDR_WIDTH +: ADDR_WIDTH] : req_addr[0 +: ADDR_WIDTH];
  assign win_wdata = win ? req_wdata[DATA_WIDTH +: DATA_WIDTH] : req_wdata[0 +: DATA_WIDTH];
  assign win_we    = win ? req_we[1] : req_we[0];
  assign addr_ext  = 32'(win_addr);
  assign win_err   = (win_we && (addr_ext < ROM_END)) || (addr_ext >= RAM_END);

  // Memory is driven straight from the winning request in the accept cycle only.
  assign req_ready   = accept ? (win ? 2'b10 : 2'b01) : 2'b00;
  assign mem_address = accept ? win_addr : '0;
  assign mem_w_data  = accept ? win_wdata : '0;
  assign mem_ctrl_r  = accept && !win_we && !win_err;
  assign mem_ctrl_w  = accept && win_we && !win_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            owner_q <= win;
            we_q    <= win_we;
            err_q   <= win_err;
            state   <= S_MEM;
          end
        end
        S_MEM: begin
          rdata_q <= (we_q || err_q) ? '0 : mem_r_data;
          state   <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready[owner_q]) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid = (state == S_RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign busy      = (state != S_IDLE);
  assign owner     = owner_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Randomized bench for data_memory_arbiter with a transaction-level reference model and a data_memory stand-in.
// Honours DMEM_ARB_ROUND_ROBIN_EN when computing expected grants.
module tb_data_memory_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_we;
  logic [19:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [9:0]  mem_address;
  logic [31:0] mem_w_data;
  logic        mem_ctrl_w;
  logic        mem_ctrl_r;
  logic [31:0] mem_r_data;
  logic        busy;
  logic        owner;

  int n_checks = 0;
  int n_errors = 0;

  data_memory_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_address(mem_address), .mem_w_data(mem_w_data),
    .mem_ctrl_w(mem_ctrl_w), .mem_ctrl_r(mem_ctrl_r), .mem_r_data(mem_r_data),
    .busy(busy), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data_memory stand-in: registered read, synchronous write
  logic [31:0] dmem [1024];
  always @(posedge clk) begin
    if (mem_ctrl_w) dmem[mem_address] <= mem_w_data;
    if (mem_ctrl_r) mem_r_data <= dmem[mem_address];
  end

  // Reference state: expected memory contents, pending requests, arbitration pointer
  logic [31:0] ref_mem [1024];
  bit          pv  [2];
  bit          pwe [2];
  logic [9:0]  pad [2];
  logic [31:0] pwd [2];
  bit          rr_ptr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit pick(input bit v0, input bit v1);
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    if (v0 && v1) return rr_ptr;
    return v0 ? 1'b0 : 1'b1;
`else
    return v0 ? 1'b0 : 1'b1;
`endif
  endfunction

  task automatic drive_reqs();
    req_valid = {pv[1], pv[0]};
    req_we    = {pwe[1], pwe[0]};
    req_addr  = {pad[1], pad[0]};
    req_wdata = {pwd[1], pwd[0]};
  endtask

  task automatic set_req(input int p, input bit we, input logic [9:0] a, input logic [31:0] d);
    pv[p] = 1'b1; pwe[p] = we; pad[p] = a; pwd[p] = d;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the handshake.
  task automatic run_txn(input int delay, output bit g, output logic [31:0] got_rdata);
    logic [9:0]  ea;
    logic [31:0] ewd;
    logic [31:0] erd;
    bit          ewe;
    bit          eerr;
    drive_reqs();
    #1;
    g    = pick(pv[0], pv[1]);
    ea   = pad[g];
    ewe  = pwe[g];
    ewd  = pwd[g];
    eerr = (ewe && ea < 10'd256) || ea >= 10'd512;
    erd  = (eerr || ewe) ? 32'h0 : ref_mem[ea];
    if (!eerr && ewe) ref_mem[ea] = ewd;
    rr_ptr = ~g;
    chk("idle_busy", {31'h0, busy}, 32'h0);
    chk("accept_req_ready", {30'h0, req_ready}, g ? 32'h2 : 32'h1);
    chk("accept_mem_addr", {22'h0, mem_address}, {22'h0, ea});
    chk("accept_mem_r", {31'h0, mem_ctrl_r}, {31'h0, !ewe && !eerr});
    chk("accept_mem_w", {31'h0, mem_ctrl_w}, {31'h0, ewe && !eerr});
    if (ewe && !eerr) chk("accept_mem_wdata", mem_w_data, ewd);
    @(negedge clk);
    pv[g] = 1'b0;
    drive_reqs();
    #1;
    chk("mem_busy", {31'h0, busy}, 32'h1);
    chk("mem_owner", {31'h0, owner}, {31'h0, g});
    chk("mem_req_ready", {30'h0, req_ready}, 32'h0);
    chk("mem_ctrl", {30'h0, mem_ctrl_r, mem_ctrl_w}, 32'h0);
    chk("mem_rsp_valid", {30'h0, rsp_valid}, 32'h0);
    for (int i = 0; i <= delay; i++) begin
      @(negedge clk);
      rsp_ready[~g] = 1'($urandom_range(0, 1));
      rsp_ready[g]  = (i == delay);
      #1;
      chk("resp_valid", {30'h0, rsp_valid}, g ? 32'h2 : 32'h1);
      chk("resp_rdata", rsp_rdata, erd);
      chk("resp_err", {31'h0, rsp_err}, {31'h0, eerr});
      chk("resp_req_ready", {30'h0, req_ready}, 32'h0);
    end
    got_rdata = rsp_rdata;
    @(negedge clk);
    rsp_ready = 2'b00;
  endtask

  bit          g;
  logic [31:0] rd;
  bit [3:0]    grants;

  initial begin
    for (int a = 0; a < 1024; a++) begin
      dmem[a]    = 32'hA5A5_0000 ^ a;
      ref_mem[a] = 32'hA5A5_0000 ^ a;
    end
    dmem[5]    = 32'hDEAD_BEEF;
    ref_mem[5] = 32'hDEAD_BEEF;
    for (int p = 0; p < 2; p++) begin
      pv[p] = 0; pwe[p] = 0; pad[p] = '0; pwd[p] = '0;
    end
    rr_ptr    = 1'b0;
    rsp_ready = 2'b00;
    rst_n     = 1'b0;
    drive_reqs();
    #12;
    chk("rst_req_ready", {30'h0, req_ready}, 32'h0);
    chk("rst_rsp_valid", {30'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_misc", {26'h0, rsp_err, mem_ctrl_w, mem_ctrl_r, busy, owner, 1'b0}, 32'h0);
    chk("rst_mem_addr", {22'h0, mem_address}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Contention: both ports keep a read pending for four transactions
    set_req(0, 1'b0, 10'h005, 32'h0);
    set_req(1, 1'b0, 10'h101, 32'h0);
    for (int t = 0; t < 4; t++) begin
      run_txn(0, g, rd);
      grants[t] = g;
      if (g) set_req(1, 1'b0, 10'(10'h101 + t), 32'h0);
      else   set_req(0, 1'b0, 10'(10'h005 + t), 32'h0);
    end
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    chk("contention_grants", {28'h0, grants}, 32'hA);
`else
    chk("contention_grants", {28'h0, grants}, 32'h0);
`endif
    pv[0] = 0; pv[1] = 0;

    // ROM read of the known word
    set_req(0, 1'b0, 10'h005, 32'h0);
    run_txn(0, g, rd);
    chk("rom_read_value", rd, 32'hDEAD_BEEF);

    // RAM write from port 1, read back from port 0
    set_req(1, 1'b1, 10'h120, 32'h1234_5678);
    run_txn(0, g, rd);
    set_req(0, 1'b0, 10'h120, 32'h0);
    run_txn(1, g, rd);
    chk("ram_readback", rd, 32'h1234_5678);

    // Error cases: ROM write and out-of-range read
    set_req(0, 1'b1, 10'h010, 32'hFFFF_FFFF);
    run_txn(0, g, rd);
    set_req(0, 1'b0, 10'h200, 32'h0);
    run_txn(0, g, rd);
    chk("rom_unchanged", dmem[10'h010], 32'hA5A5_0010);

    // Reset pulse while in MEM
    set_req(0, 1'b0, 10'h130, 32'h0);
    drive_reqs();
    @(negedge clk);
    pv[0] = 0;
    drive_reqs();
    rst_n = 1'b0;
    rr_ptr = 1'b0;
    #1;
    chk("rstmem_busy", {31'h0, busy}, 32'h0);
    chk("rstmem_outputs", {26'h0, rsp_valid, rsp_err, mem_ctrl_w, mem_ctrl_r, owner}, 32'h0);
    chk("rstmem_rdata", rsp_rdata, 32'h0);
    chk("rstmem_req_ready", {30'h0, req_ready}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstmem_no_rsp", {30'h0, rsp_valid}, 32'h0);
    end

    // Long RESP hold on port 0 with port 1 waiting behind it
    set_req(0, 1'b0, 10'h005, 32'h0);
    set_req(1, 1'b1, 10'h1FF, 32'hCAFE_F00D);
    run_txn(5, g, rd);
    chk("hold_first_owner", {31'h0, g}, 32'h0);
    run_txn(0, g, rd);
    chk("hold_second_owner", {31'h0, g}, 32'h1);
    chk("hold_write_landed", dmem[10'h1FF], 32'hCAFE_F00D);

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pv[p] && $urandom_range(0, 2) != 0) begin
          set_req(p, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023))
                                              : 10'($urandom_range(256, 511)),
                  $urandom);
        end
      end
      if (!pv[0] && !pv[1]) set_req(0, 1'b0, 10'($urandom_range(0, 511)), 32'h0);
      run_txn($urandom_range(0, 2), g, rd);
    end
    pv[0] = 0; pv[1] = 0;
    drive_reqs();

    for (int a = 256; a < 512; a++) begin
      if (dmem[a] !== ref_mem[a]) chk("final_ram", dmem[a], ref_mem[a]);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
